// File: rtl/pcie_rx_detect.sv
// pcie_rx_detect: receiver-detect sequencer with two-pass confirmation of the lane mask.
// Ports:
//    clk_i                   - single clock
//    rst_i                   - asynchronous active-low reset
//    start_i                 - level enable; high runs detection, low aborts/releases
//    phy_rx_present_i        - per-lane comparator outputs (asynchronous, synchronized here)
//    phy_tx_detect_o         - registered detect pulse to the PHY transmitter
//    phy_layer_lane_detect_o - registered confirmed-detection flag to pcie_controller
//    lanes_detected_o        - confirmed lane mask, zero unless detection is confirmed
//    busy_o                  - high while a detection sequence is in progress
module pcie_rx_detect #(
   parameter int NUM_LANES_SUPPORTED = 1,
   parameter int QUIET_CYCLES        = 64,
   parameter int DETECT_PULSE_CYCLES = 16,
   parameter int SETTLE_CYCLES       = 32
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           start_i,
   input  logic [NUM_LANES_SUPPORTED-1:0] phy_rx_present_i,
   output logic                           phy_tx_detect_o,
   output logic                           phy_layer_lane_detect_o,
   output logic [NUM_LANES_SUPPORTED-1:0] lanes_detected_o,
   output logic                           busy_o
);
   localparam int MAXC = (QUIET_CYCLES > DETECT_PULSE_CYCLES)
                         ? ((QUIET_CYCLES > SETTLE_CYCLES) ? QUIET_CYCLES : SETTLE_CYCLES)
                         : ((DETECT_PULSE_CYCLES > SETTLE_CYCLES) ? DETECT_PULSE_CYCLES : SETTLE_CYCLES);
   localparam int CW = $clog2(MAXC + 1);
   localparam logic [CW-1:0] Q_LD = CW'(QUIET_CYCLES);
   localparam logic [CW-1:0] P_LD = CW'(DETECT_PULSE_CYCLES);
   localparam logic [CW-1:0] S_LD = CW'(SETTLE_CYCLES);

   typedef enum logic [2:0] {IDLE, QUIET, PULSE, SETTLE, DETECTED} state_e;

   state_e                         state_q, state_d;
   logic [CW-1:0]                  cnt_q, cnt_d;
   logic                           pass_q, pass_d;
   logic [NUM_LANES_SUPPORTED-1:0] first_q, first_d;
   logic [NUM_LANES_SUPPORTED-1:0] lanes_q, lanes_d;
   logic [NUM_LANES_SUPPORTED-1:0] sync1_q, sync2_q;
   logic                           tx_q, det_q, busy_q;
   logic                           last;

   assign last = (cnt_q == CW'(1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;
      first_d = first_q;
      lanes_d = lanes_q;
      if (state_q != IDLE && !start_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         pass_d  = 1'b0;
         lanes_d = '0;
      end else begin
         case (state_q)
            IDLE: if (start_i) begin
               state_d = QUIET;
               cnt_d   = Q_LD;
               pass_d  = 1'b0;
            end
            QUIET: begin
               cnt_d   = last ? P_LD : cnt_q - CW'(1);
               state_d = last ? PULSE : QUIET;
            end
            PULSE: begin
               cnt_d   = last ? S_LD : cnt_q - CW'(1);
               state_d = last ? SETTLE : PULSE;
            end
            SETTLE: if (!last) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               state_d = QUIET;
               cnt_d   = Q_LD;
               if (sync2_q == '0) begin
                  pass_d = 1'b0;
               end else if (pass_q && sync2_q == first_q) begin
                  state_d = DETECTED;
                  cnt_d   = '0;
                  lanes_d = sync2_q;
               end else begin
                  // a differing second mask restarts confirmation with itself as the first pass
                  first_d = sync2_q;
                  pass_d  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pass_q  <= 1'b0;
         first_q <= '0;
         lanes_q <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         tx_q    <= 1'b0;
         det_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
         first_q <= first_d;
         lanes_q <= lanes_d;
         sync1_q <= phy_rx_present_i;
         sync2_q <= sync1_q;
         // outputs are decoded from the next state so they line up with the state they describe
         tx_q    <= (state_d == PULSE);
         det_q   <= (state_d == DETECTED);
         busy_q  <= (state_d == QUIET) || (state_d == PULSE) || (state_d == SETTLE);
      end
   end

   assign phy_tx_detect_o         = tx_q;
   assign phy_layer_lane_detect_o = det_q;
   assign lanes_detected_o        = lanes_q;
   assign busy_o                  = busy_q;
endmodule

// File: tb/tb_pcie_rx_detect.sv
// tb_pcie_rx_detect: self-checking bench for pcie_rx_detect (table vectors, corner sequences, random vs model).
module tb_pcie_rx_detect;
   localparam int N = 4, Q = 4, P = 2, S = 3, T = Q + P + S;

   logic         clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0;
   logic [N-1:0] phy_rx_present_i = '0;
   logic         phy_tx_detect_o, phy_layer_lane_detect_o, busy_o;
   logic [N-1:0] lanes_detected_o;

   always #5 clk_i = ~clk_i;

   pcie_rx_detect #(.NUM_LANES_SUPPORTED(N), .QUIET_CYCLES(Q), .DETECT_PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .phy_rx_present_i(phy_rx_present_i),
      .phy_tx_detect_o(phy_tx_detect_o), .phy_layer_lane_detect_o(phy_layer_lane_detect_o),
      .lanes_detected_o(lanes_detected_o), .busy_o(busy_o));

   int checks = 0, errors = 0;

   // reference model: position within a pass of T cycles, plus confirmation bookkeeping
   bit           m_run, m_det, m_pass;
   int           m_c;
   logic [N-1:0] m_first, m_lanes, h1, h2;

   function automatic void model_reset();
      m_run = 0; m_det = 0; m_pass = 0; m_c = 0;
      m_first = '0; m_lanes = '0; h1 = '0; h2 = '0;
   endfunction

   task automatic model_edge();
      logic [N-1:0] m;
      m  = h2;
      h2 = h1;
      h1 = phy_rx_present_i;
      if (!start_i) begin
         m_run = 0; m_det = 0; m_lanes = '0; m_pass = 0;
      end else if (!m_run && !m_det) begin
         m_run = 1; m_c = 1; m_pass = 0;
      end else if (m_run) begin
         if (m_c < T) m_c++;
         else begin
            m_c = 1;
            if (m == '0) m_pass = 0;
            else if (m_pass && m == m_first) begin m_run = 0; m_det = 1; m_lanes = m; end
            else begin m_first = m; m_pass = 1; end
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      model_edge();
      #1;
      chk("model_tx", 32'(phy_tx_detect_o), 32'(m_run && m_c > Q && m_c <= Q + P));
      chk("model_det", 32'(phy_layer_lane_detect_o), 32'(m_det));
      chk("model_lanes", 32'(lanes_detected_o), 32'(m_lanes));
      chk("model_busy", 32'(busy_o), 32'(m_run));
   endtask

   typedef struct {
      int           cyc;
      logic         tx, det, busy;
      logic [N-1:0] lanes;
   } vec_t;

   vec_t tbl[12];
   int   first_cyc, pulses;
   bit   det_seen, idle_seen, prev_tx;

   initial begin
      tbl = '{'{1, 1'b0, 1'b0, 1'b1, 4'h0}, '{4, 1'b0, 1'b0, 1'b1, 4'h0}, '{5, 1'b1, 1'b0, 1'b1, 4'h0},
              '{6, 1'b1, 1'b0, 1'b1, 4'h0}, '{7, 1'b0, 1'b0, 1'b1, 4'h0}, '{13, 1'b0, 1'b0, 1'b1, 4'h0},
              '{14, 1'b1, 1'b0, 1'b1, 4'h0}, '{15, 1'b1, 1'b0, 1'b1, 4'h0}, '{16, 1'b0, 1'b0, 1'b1, 4'h0},
              '{18, 1'b0, 1'b0, 1'b1, 4'h0}, '{19, 1'b0, 1'b1, 1'b0, 4'h1}, '{22, 1'b0, 1'b1, 1'b0, 4'h1}};
      model_reset();
      #2;
      chk("reset_tx", 32'(phy_tx_detect_o), 0);
      chk("reset_det", 32'(phy_layer_lane_detect_o), 0);
      chk("reset_lanes", 32'(lanes_detected_o), 0);
      chk("reset_busy", 32'(busy_o), 0);
      #10;
      rst_i = 1'b1;
      start_i = 1'b1;
      phy_rx_present_i = 4'b0001;
      // lane 0 present: pulses at 5-6 and 14-15, detect at 2T+1
      for (int cyc = 1; cyc <= 22; cyc++) begin
         tick();
         foreach (tbl[i]) if (tbl[i].cyc == cyc) begin
            chk("tbl_tx", 32'(phy_tx_detect_o), 32'(tbl[i].tx));
            chk("tbl_det", 32'(phy_layer_lane_detect_o), 32'(tbl[i].det));
            chk("tbl_busy", 32'(busy_o), 32'(tbl[i].busy));
            chk("tbl_lanes", 32'(lanes_detected_o), 32'(tbl[i].lanes));
         end
      end
      // comparator changes in DETECTED are ignored
      for (int i = 0; i < 10; i++) begin
         phy_rx_present_i = 4'($urandom);
         tick();
         chk("det_hold_lanes", 32'(lanes_detected_o), 32'h1);
         chk("det_hold_tx", 32'(phy_tx_detect_o), 0);
      end
      // asynchronous reset in DETECTED clears outputs without a clock edge
      phy_rx_present_i = 4'b0001;
      @(posedge clk_i);
      #2 rst_i = 1'b0;
      #1;
      chk("async_rst_det", 32'(phy_layer_lane_detect_o), 0);
      chk("async_rst_lanes", 32'(lanes_detected_o), 0);
      model_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      first_cyc = 0;
      for (int cyc = 1; cyc <= 25; cyc++) begin
         tick();
         if (first_cyc == 0 && phy_layer_lane_detect_o) first_cyc = cyc;
      end
      chk("post_rst_detect_cycle", 32'(first_cyc), 32'(2 * T + 1));
      // abort mid-pulse, then restart
      start_i = 1'b0;
      tick();
      start_i = 1'b1;
      for (int cyc = 1; cyc <= 5; cyc++) tick();
      chk("mid_pulse_tx_high", 32'(phy_tx_detect_o), 1);
      start_i = 1'b0;
      tick();
      chk("abort_tx", 32'(phy_tx_detect_o), 0);
      chk("abort_busy", 32'(busy_o), 0);
      start_i = 1'b1;
      first_cyc = 0;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         tick();
         if (first_cyc == 0 && phy_tx_detect_o) first_cyc = cyc;
      end
      chk("restart_first_pulse", 32'(first_cyc), 32'(Q + 1));
      // no receiver: pulses every T cycles forever, never detects
      start_i = 1'b0;
      phy_rx_present_i = '0;
      tick();
      start_i = 1'b1;
      pulses = 0; det_seen = 0; idle_seen = 0; prev_tx = 0;
      for (int cyc = 1; cyc <= 5 * T; cyc++) begin
         tick();
         if (phy_tx_detect_o && !prev_tx) pulses++;
         prev_tx = phy_tx_detect_o;
         if (phy_layer_lane_detect_o) det_seen = 1;
         if (!busy_o) idle_seen = 1;
      end
      chk("no_rx_pulses", 32'(pulses), 5);
      chk("no_rx_det", 32'(det_seen), 0);
      chk("no_rx_busy", 32'(idle_seen), 0);
      // mismatched first pass: 0011 then 1111, confirm at 3T+1
      start_i = 1'b0;
      phy_rx_present_i = 4'b0011;
      tick();
      tick();
      start_i = 1'b1;
      for (int cyc = 1; cyc <= 3 * T + 1; cyc++) begin
         tick();
         if (cyc == 8) phy_rx_present_i = 4'b1111;
         if (cyc == 2 * T + 1) chk("mask_no_det_pass2", 32'(phy_layer_lane_detect_o), 0);
         if (cyc == 3 * T) chk("mask_no_det_early", 32'(phy_layer_lane_detect_o), 0);
      end
      chk("mask_det_pass3", 32'(phy_layer_lane_detect_o), 1);
      chk("mask_lanes_pass3", 32'(lanes_detected_o), 32'hF);
      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0)
            case ($urandom_range(0, 3))
               0: phy_rx_present_i = '0;
               1: phy_rx_present_i = 4'b0011;
               2: phy_rx_present_i = 4'b1111;
               default: phy_rx_present_i = 4'($urandom);
            endcase
         start_i = ($urandom_range(0, 39) != 0);
         tick();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pcie_rx_detect.md
# pcie_rx_detect

Physical-layer receiver-detection sequencer that drives the PHY's detect pulse, samples the per-lane receiver-present comparators and confirms the result over two consecutive passes. It sits directly upstream of `pcie_controller`: its `phy_layer_lane_detect_o` feeds the controller's `phy_layer_lane_detect_i`. It also reports the confirmed lane mask for lane-width decisions.

## Interface
- `NUM_LANES_SUPPORTED`, 1: number of lanes; width of the per-lane buses.
- `QUIET_CYCLES`, 64: idle cycles before each detect pulse. Must be ≥1.
- `DETECT_PULSE_CYCLES`, 16: cycles `phy_tx_detect_o` is held high per pass. Must be ≥1.
- `SETTLE_CYCLES`, 32: cycles after the pulse before the comparator sample. Must be ≥3.

Ports:
- `clk_i`, in, 1: single clock.
- `rst_i`, in, 1: reset, asynchronous assert, active-low.
- `start_i`, in, 1: level enable. High requests detection; low aborts or releases.
- `phy_rx_present_i`, in, NUM_LANES_SUPPORTED: analog comparator outputs, asynchronous to `clk_i`.
- `phy_tx_detect_o`, out, 1: detect pulse to the PHY transmitter.
- `phy_layer_lane_detect_o`, out, 1: confirmed detection, to `pcie_controller`.
- `lanes_detected_o`, out, NUM_LANES_SUPPORTED: confirmed lane mask, valid while `phy_layer_lane_detect_o`=1, otherwise 0.
- `busy_o`, out, 1: high in every state except IDLE and DETECTED.

## Operation
- `phy_rx_present_i` passes through a 2-flop synchronizer per bit. All sampling uses the synchronized value.
- FSM states: IDLE, QUIET, PULSE, SETTLE, DETECTED. Internal registers:
  - one down-counter, width `$clog2(max(QUIET,PULSE,SETTLE)+1)`;
  - `pass` (1 bit);
  - `first_mask` (NUM_LANES_SUPPORTED bits).
- IDLE: when `start_i`=1, load the counter with QUIET_CYCLES, set `pass`=0, go to QUIET.
- QUIET: count down. On the last cycle, load DETECT_PULSE_CYCLES and go to PULSE.
- PULSE: `phy_tx_detect_o`=1 for every PULSE cycle and no other. On the last cycle, load SETTLE_CYCLES and go to SETTLE.
- SETTLE: on the last cycle, sample synchronized mask M.
  - M=0: `pass`←0, go to QUIET (retry indefinitely).
  - M≠0 and `pass`=0: `first_mask`←M, `pass`←1, go to QUIET.
  - M≠0, `pass`=1, M==`first_mask`: register M into `lanes_detected_o`, go to DETECTED.
  - M≠0, `pass`=1, M≠`first_mask`: `first_mask`←M, `pass` stays 1, go to QUIET. The new mask becomes the first pass of the next confirmation.
- DETECTED: `phy_layer_lane_detect_o`=1; outputs hold while `start_i`=1. Changes on `phy_rx_present_i` are ignored.
- `start_i`=0 in any state other than IDLE: next state is IDLE. `phy_tx_detect_o` drops on that same edge, even mid-PULSE. `phy_layer_lane_detect_o`, `lanes_detected_o` and `pass` clear.
- Reset (`rst_i`=0), asynchronous:
  - state IDLE; counter, `pass`, `first_mask` and synchronizer flops cleared;
  - `phy_tx_detect_o`=0, `phy_layer_lane_detect_o`=0, `lanes_detected_o`=0, `busy_o`=0.
  - Reset mid-pulse drops `phy_tx_detect_o` immediately.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Timing
- Edge 0 samples `start_i`=1 in IDLE. QUIET occupies cycles 1..Q, PULSE cycles Q+1..Q+P, SETTLE cycles Q+P+1..Q+P+S. One pass T = Q+P+S.
- The sample at the end of SETTLE sees the comparator value from 2 cycles earlier, because of the synchronizer.
- Best case, `phy_layer_lane_detect_o` and `lanes_detected_o` rise at cycle 2T+1. With defaults T=112, that is cycle 225.
- `busy_o` rises at cycle 1 and falls on the same edge `phy_layer_lane_detect_o` rises.
- Release: `start_i` sampled low at edge n gives all outputs low from cycle n+1.
- Restarting requires `start_i` to be seen low for at least one edge. A new run begins from IDLE with `pass`=0.

## Test plan
- Reset then start; lane 0 present throughout (Q=4, P=2, S=3, N=1). Required: `phy_tx_detect_o` high exactly cycles 5–6 and 14–15; detect and `lanes_detected_o`=1 at cycle 19; `busy_o` falls at cycle 19.
- `phy_rx_present_i`=0 throughout. Required: `phy_tx_detect_o` pulses every T cycles indefinitely; detect never asserts; `busy_o` stays 1.
- N=4; first pass mask 4'b0011, then 4'b1111 for all later passes. Required: no detect after pass 2; detect with mask 4'b1111 at the end of pass 3, cycle 3T+1.
- Deassert `start_i` in the middle of the PULSE window. Required: `phy_tx_detect_o` low next cycle; state IDLE; reasserting `start_i` gives the first pulse Q cycles later.
- Assert `rst_i`=0 asynchronously in DETECTED. Required: detect and `lanes_detected_o` clear without waiting for a clock edge; after release they remain 0 until a full 2T sequence completes.
- In DETECTED, toggle `phy_rx_present_i`. Required: `lanes_detected_o` is unchanged and `phy_tx_detect_o` stays 0.
